// File: rtl/ccff_loader_pkg.sv
// rtl/ccff_loader_pkg.sv - shared types and constants for the configuration-chain loader
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } ccff_state_e;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // Number of bitstream words needed to cover the whole chain.
  function automatic int words_per_load(input int chain_len, input int word_w);
    return (chain_len + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/ccff_crc16_step.sv
// rtl/ccff_crc16_step.sv - one-bit MSB-first CRC-16 update
module ccff_crc16_step
  import ccff_loader_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic        bit_in,
  output logic [15:0] crc_out
);

  logic fb;

  always_comb begin
    fb      = crc_in[15] ^ bit_in;
    crc_out = {crc_in[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
  end

endmodule

// File: rtl/ccff_bitstream_loader.sv
// rtl/ccff_bitstream_loader.sv - serialises bitstream words into a config chain, signs the readback
module ccff_bitstream_loader
  import ccff_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 56,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] bs_data,
  input  logic              bs_valid,
  output logic              bs_ready,
  output logic              ccff_head,
  output logic              ccff_clk_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic [15:0]       rb_sig
);

  localparam int CNT_W  = $clog2(CHAIN_LEN + 1);
  localparam int NWORDS = words_per_load(CHAIN_LEN, WORD_W);
  localparam int WCNT_W = $clog2(NWORDS + 1);
  localparam int SCNT_W = $clog2(WORD_W + 1);

  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(CHAIN_LEN);
  localparam logic [WCNT_W-1:0] WORDS_MAX = WCNT_W'(NWORDS);
  localparam logic [SCNT_W-1:0] SR_FULL   = SCNT_W'(WORD_W);
  localparam logic [SCNT_W-1:0] SR_ONE    = SCNT_W'(1);

  ccff_state_e        state_q, state_d;
  logic [WORD_W-1:0]  hold_q;
  logic               hold_full_q;
  logic [WORD_W-1:0]  sr_q;
  logic [SCNT_W-1:0]  sr_cnt_q;
  logic [CNT_W-1:0]   bit_cnt_q;
  logic [WCNT_W-1:0]  words_q;
  logic               head_q;
  logic               clk_en_q;
  logic [15:0]        rb_q;
  logic [15:0]        crc_next;

  logic restart;
  logic accept;
  logic issue;
  logic refill;

  ccff_crc16_step u_crc (
    .crc_in  (rb_q),
    .bit_in  (ccff_tail),
    .crc_out (crc_next)
  );

  // State register
  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start) state_d = LOAD;
        LOAD:    if (bit_cnt_q == LAST_CNT) state_d = DRAIN;
        DRAIN:   state_d = DONE;
        DONE:    if (start) state_d = LOAD;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output and datapath-control decode
  always_comb begin
    busy     = (state_q == LOAD) || (state_q == DRAIN);
    done     = (state_q == DONE);
    bs_ready = (state_q == LOAD) && !hold_full_q && (words_q < WORDS_MAX);
    restart  = start && ((state_q == IDLE) || (state_q == DONE));
    accept   = bs_valid && bs_ready;
    issue    = (state_q == LOAD) && (sr_cnt_q != '0) && (bit_cnt_q != LAST_CNT);
    // Refill on the same edge that issues the last buffered bit so the stream has no bubble.
    refill   = (state_q == LOAD) && hold_full_q &&
               ((sr_cnt_q == '0) || (issue && (sr_cnt_q == SR_ONE)));
  end

  // Datapath: hold/shift buffering, chain drive, readback signature
  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      sr_q        <= '0;
      sr_cnt_q    <= '0;
      bit_cnt_q   <= '0;
      words_q     <= '0;
      head_q      <= 1'b0;
      clk_en_q    <= 1'b0;
      rb_q        <= CRC_INIT;
    end else if (abort) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      sr_q        <= '0;
      sr_cnt_q    <= '0;
      bit_cnt_q   <= '0;
      words_q     <= '0;
      head_q      <= 1'b0;
      clk_en_q    <= 1'b0;
      rb_q        <= CRC_INIT;
    end else if (restart) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      sr_q        <= '0;
      sr_cnt_q    <= '0;
      bit_cnt_q   <= '0;
      words_q     <= '0;
      clk_en_q    <= 1'b0;
      rb_q        <= CRC_INIT;
    end else begin
      if (clk_en_q) begin
        rb_q <= crc_next;
      end

      if (accept) begin
        hold_q      <= bs_data;
        hold_full_q <= 1'b1;
        words_q     <= words_q + WCNT_W'(1);
      end else if (refill) begin
        hold_full_q <= 1'b0;
      end

      if (refill) begin
        sr_q     <= hold_q;
        sr_cnt_q <= SR_FULL;
      end else if (issue) begin
        sr_q     <= sr_q >> 1;
        sr_cnt_q <= sr_cnt_q - SR_ONE;
      end

      if (issue) begin
        head_q    <= sr_q[0];
        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
      end
      clk_en_q <= issue;
    end
  end

  assign ccff_head   = head_q;
  assign ccff_clk_en = clk_en_q;
  assign rb_sig      = rb_q;

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// tb/tb_ccff_bitstream_loader.sv - directed self-checking bench for ccff_bitstream_loader
module tb_ccff_bitstream_loader;

  logic        prog_clk = 1'b0;
  logic        pReset   = 1'b0;
  logic        start    = 1'b0;
  logic        abort    = 1'b0;
  logic [7:0]  bs_data  = '0;
  logic        bs_valid = 1'b0;
  logic        bs_ready, ccff_head, ccff_clk_en, ccff_tail, busy, done;
  logic [15:0] rb_sig;

  logic        start13    = 1'b0;
  logic        abort13    = 1'b0;
  logic [7:0]  bs_data13  = '0;
  logic        bs_valid13 = 1'b0;
  logic        tail13     = 1'b0;
  logic        bs_ready13, ccff_head13, ccff_clk_en13, busy13, done13;
  logic [15:0] rb_sig13;

  int checks = 0;
  int errors = 0;

  always #5 prog_clk = ~prog_clk;

  ccff_bitstream_loader #(.CHAIN_LEN(56), .WORD_W(8)) u_dut (
    .prog_clk    (prog_clk),
    .pReset      (pReset),
    .start       (start),
    .abort       (abort),
    .bs_data     (bs_data),
    .bs_valid    (bs_valid),
    .bs_ready    (bs_ready),
    .ccff_head   (ccff_head),
    .ccff_clk_en (ccff_clk_en),
    .ccff_tail   (ccff_tail),
    .busy        (busy),
    .done        (done),
    .rb_sig      (rb_sig)
  );

  ccff_bitstream_loader #(.CHAIN_LEN(13), .WORD_W(8)) u_dut13 (
    .prog_clk    (prog_clk),
    .pReset      (pReset),
    .start       (start13),
    .abort       (abort13),
    .bs_data     (bs_data13),
    .bs_valid    (bs_valid13),
    .bs_ready    (bs_ready13),
    .ccff_head   (ccff_head13),
    .ccff_clk_en (ccff_clk_en13),
    .ccff_tail   (tail13),
    .busy        (busy13),
    .done        (done13),
    .rb_sig      (rb_sig13)
  );

  // Enable/head monitor for the 56-bit instance
  int          cyc      = 0;
  int          en_cnt   = 0;
  int          en_first = 0;
  int          en_last  = 0;
  logic [63:0] got_bits = '0;
  logic        clr_mon  = 1'b0;

  always @(posedge prog_clk) begin
    cyc = cyc + 1;
    if (clr_mon) begin
      en_cnt   = 0;
      got_bits = '0;
    end else if (ccff_clk_en) begin
      if (en_cnt < 64) got_bits[en_cnt] = ccff_head;
      if (en_cnt == 0) en_first = cyc;
      en_last = cyc;
      en_cnt  = en_cnt + 1;
    end
  end

  // 56-flop chain: head enters chain[0], tail is chain[55]
  logic [55:0] chain = '0;
  logic [55:0] preload_val = '0;
  logic        preload = 1'b0;

  always @(posedge prog_clk) begin
    if (preload) chain <= preload_val;
    else if (ccff_clk_en) chain <= {chain[54:0], ccff_head};
  end
  assign ccff_tail = chain[55];

  int          en13 = 0;
  logic [63:0] h13  = '0;

  always @(posedge prog_clk) begin
    if (ccff_clk_en13) begin
      if (en13 < 64) h13[en13] = ccff_head13;
      en13 = en13 + 1;
    end
  end

  logic [7:0] words [7];
  logic [7:0] a5 = 8'hA5;
  int         acc_cyc = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] crc_ref(input logic [63:0] bits, input int n);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      if (c[15] != bits[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  function automatic logic [63:0] stream_of_words();
    logic [63:0] b;
    logic [7:0]  w;
    b = '0;
    for (int i = 0; i < 56; i++) begin
      w    = words[i / 8];
      b[i] = w[i % 8];
    end
    return b;
  endfunction

  task automatic clear_mon();
    @(negedge prog_clk);
    clr_mon = 1'b1;
    @(negedge prog_clk);
    clr_mon = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge prog_clk);
    start = 1'b1;
    @(negedge prog_clk);
    start = 1'b0;
  endtask

  task automatic feed(input int n, input bit gaps);
    int i;
    int t;
    i = 0;
    t = 0;
    while (i < n && t < 400) begin
      @(negedge prog_clk);
      if (gaps && ((t % 24) >= 4)) begin
        bs_valid = 1'b0;
      end else begin
        bs_valid = 1'b1;
        bs_data  = words[i];
      end
      #4;
      if (bs_valid && bs_ready) begin
        if (i == 0) acc_cyc = cyc;
        i++;
      end
      t++;
    end
    @(negedge prog_clk);
    bs_valid = 1'b0;
    chk("feed_words", i, n);
  endtask

  task automatic wait_done(output int dc);
    int n;
    n = 0;
    while (!done && n < 300) begin
      @(negedge prog_clk);
      n++;
    end
    dc = cyc;
    chk("done_reached", done, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [63:0] exp_bits;
    logic [63:0] a5_bits;
    logic [63:0] snap_bits;
    int          done_cyc;
    int          n;
    int          acc13;

    a5_bits = '0;
    for (int i = 0; i < 56; i++) a5_bits[i] = a5[i % 8];
    for (int i = 0; i < 56; i++) preload_val[55 - i] = a5_bits[i];

    // Reset values
    preload = 1'b1;
    repeat (3) @(negedge prog_clk);
    chk("rst_bs_ready", bs_ready, 1'b0);
    chk("rst_head", ccff_head, 1'b0);
    chk("rst_clk_en", ccff_clk_en, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_rb_sig", rb_sig, 16'hFFFF);
    pReset  = 1'b1;
    preload = 1'b0;

    // Load 1: back-to-back words 0x01..0x07
    for (int i = 0; i < 7; i++) words[i] = 8'(i + 1);
    exp_bits = stream_of_words();
    clear_mon();
    pulse_start();
    chk("t1_busy_start", busy, 1'b1);
    feed(7, 1'b0);
    chk("t1_ready_after7", bs_ready, 1'b0);
    chk("t1_busy_load", busy, 1'b1);
    wait_done(done_cyc);
    chk("t1_done_after_drain", done_cyc, en_last + 1);
    chk("t1_latency", en_first, acc_cyc + 4);
    chk("t1_en_count", en_cnt, 56);
    chk("t1_contiguous", en_last - en_first + 1, 56);
    chk("t1_heads", got_bits, exp_bits);
    chk("t1_rb_sig", rb_sig, crc_ref(a5_bits, 56));
    chk("t1_en_low_done", ccff_clk_en, 1'b0);
    chk("t1_busy_done", busy, 1'b0);

    // Load 2: same data with long valid gaps
    clear_mon();
    pulse_start();
    feed(7, 1'b1);
    wait_done(done_cyc);
    chk("t2_en_count", en_cnt, 56);
    chk("t2_stalled", (en_last - en_first + 1) > 56, 1'b1);
    chk("t2_heads", got_bits, exp_bits);
    chk("t2_rb_sig", rb_sig, crc_ref(exp_bits, 56));

    // Load 3: abort after 20 enables
    words[0] = 8'hDE; words[1] = 8'hAD; words[2] = 8'hBE; words[3] = 8'hEF;
    words[4] = 8'h12; words[5] = 8'h34; words[6] = 8'h56;
    clear_mon();
    pulse_start();
    feed(3, 1'b0);
    n = 0;
    while (en_cnt < 20 && n < 100) begin
      @(negedge prog_clk);
      n++;
    end
    chk("t3_reached20", en_cnt >= 20, 1'b1);
    chk("t3_busy_pre", busy, 1'b1);
    abort = 1'b1;
    @(negedge prog_clk);
    abort = 1'b0;
    chk("t3_busy", busy, 1'b0);
    chk("t3_done", done, 1'b0);
    chk("t3_clk_en", ccff_clk_en, 1'b0);
    chk("t3_bs_ready", bs_ready, 1'b0);
    chk("t3_rb_sig", rb_sig, 16'hFFFF);
    snap_bits = '0;
    for (int i = 0; i < 56; i++) snap_bits[i] = chain[55 - i];

    // Restart after abort: full 0x01..0x07 load
    for (int i = 0; i < 7; i++) words[i] = 8'(i + 1);
    exp_bits = stream_of_words();
    clear_mon();
    pulse_start();
    feed(7, 1'b0);
    wait_done(done_cyc);
    chk("t3r_en_count", en_cnt, 56);
    chk("t3r_heads", got_bits, exp_bits);
    chk("t3r_rb_sig", rb_sig, crc_ref(snap_bits, 56));

    // Asynchronous reset mid-load
    clear_mon();
    pulse_start();
    feed(2, 1'b0);
    repeat (2) @(negedge prog_clk);
    chk("t4_busy_pre", busy, 1'b1);
    chk("t4_en_pre", ccff_clk_en, 1'b1);
    #2;
    pReset = 1'b0;
    #1;
    chk("t4_busy", busy, 1'b0);
    chk("t4_done", done, 1'b0);
    chk("t4_clk_en", ccff_clk_en, 1'b0);
    chk("t4_head", ccff_head, 1'b0);
    chk("t4_bs_ready", bs_ready, 1'b0);
    chk("t4_rb_sig", rb_sig, 16'hFFFF);
    @(negedge prog_clk);
    pReset = 1'b1;

    // 13-bit chain: 0xFF, 0x1F, then a third word that must not be taken
    @(negedge prog_clk);
    start13 = 1'b1;
    @(negedge prog_clk);
    start13 = 1'b0;
    acc13 = 0;
    n = 0;
    while (!done13 && n < 80) begin
      @(negedge prog_clk);
      bs_valid13 = 1'b1;
      bs_data13  = (acc13 == 0) ? 8'hFF : (acc13 == 1) ? 8'h1F : 8'hAA;
      #4;
      if (bs_ready13) acc13++;
      n++;
    end
    bs_valid13 = 1'b0;
    chk("t5_done", done13, 1'b1);
    chk("t5_words", acc13, 2);
    chk("t5_en_count", en13, 13);
    chk("t5_heads", h13, 64'h1FFF);
    chk("t5_rb_sig", rb_sig13, crc_ref(64'h0, 13));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
